left_shift: RTL and testbench

- Left shifter for the processor datapath, e.g. branch-offset word-to-byte scaling.
- Primary path is purely combinational: data_out = data_in shifted left by a fixed amount, zero-filled.
- Secondary registered path is a variable-amount barrel shifter for pipelined use. It is clocked and has an asynchronous reset.

---
 rtl/left_shift.sv | 127 ++++++++++++
 tb/tb_left_shift.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/left_shift.sv
`default_nettype none
// ============================================================================
// Module   : left_shift
// Purpose  : Datapath left shifter.
//            - data_out : combinational, data_in << SHIFT, zero-filled.
//            - q_out    : registered, data_in << shamt, built from a 5-stage
//                         log2 barrel shifter (1, 2, 4, 8, 16).
//            Optional overflow flags are enabled by the macro
//            LEFT_SHIFT_OVF_EN (ports ovf, q_ovf, ovf_sticky).
// Revision : 1.0 - initial release
// ============================================================================
module left_shift #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  input  logic             load,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] q_out,
  output logic             q_valid
`ifdef LEFT_SHIFT_OVF_EN
  ,
  output logic             ovf,
  output logic             q_ovf,
  output logic             ovf_sticky
`endif
);

  // Number of barrel stages; one per bit of shamt.
  localparam int STAGES = 5;

  // --------------------------------------------------------------------------
  // Fixed combinational path. Depends only on data_in, so X/Z on load or
  // shamt and the state of clk/rst can never reach data_out.
  // --------------------------------------------------------------------------
  assign data_out = data_in << SHIFT;

`ifdef LEFT_SHIFT_OVF_EN
  // Fixed-path overflow: any set bit in the top SHIFT bits is lost.
  // A zero shift loses nothing, and has no top-bit slice to look at.
  generate
    if (SHIFT == 0) begin : g_ovf_none
      assign ovf = 1'b0;
    end else begin : g_ovf_lost
      assign ovf = |data_in[WIDTH-1:WIDTH-SHIFT];
    end
  endgenerate
`endif

  // --------------------------------------------------------------------------
  // Variable barrel shifter. Stage k shifts by 2**k when shamt[k] is set.
  // Each stage also reports whether it pushed a set bit off the top, and
  // those per-stage drops are OR-ed down the chain to form the overflow.
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int AMT = 1 << k;

      logic [WIDTH-1:0] w_in;
      logic [WIDTH-1:0] w_out;

      if (k == 0) begin : g_first
        assign w_in = data_in;
      end else begin : g_next
        assign w_in = g_stage[k-1].w_out;
      end

      assign w_out = shamt[k] ? {w_in[WIDTH-1-AMT:0], {AMT{1'b0}}} : w_in;

`ifdef LEFT_SHIFT_OVF_EN
      logic w_lost_in;
      logic w_lost_out;

      if (k == 0) begin : g_lost_first
        assign w_lost_in = 1'b0;
      end else begin : g_lost_next
        assign w_lost_in = g_stage[k-1].w_lost_out;
      end

      assign w_lost_out = w_lost_in | (shamt[k] & (|w_in[WIDTH-1:WIDTH-AMT]));
`endif
    end
  endgenerate

  logic [WIDTH-1:0] w_shifted;
  assign w_shifted = g_stage[STAGES-1].w_out;

`ifdef LEFT_SHIFT_OVF_EN
  logic w_lost;
  assign w_lost = g_stage[STAGES-1].w_lost_out;
`endif

  // Capture register: load samples the barrel result; q_valid pulses for one
  // cycle per capture. Reset clears the register without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_out   <= '0;
      q_valid <= 1'b0;
    end else if (load) begin
      q_out   <= w_shifted;
      q_valid <= 1'b1;
    end else begin
      q_valid <= 1'b0;
    end
  end

`ifdef LEFT_SHIFT_OVF_EN
  // Overflow flags: q_ovf travels with q_out; ovf_sticky latches any
  // overflowing capture and only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_ovf      <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (load) begin
      q_ovf <= w_lost;
      if (w_lost) begin
        ovf_sticky <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_left_shift.sv
`default_nettype none
// ============================================================================
// Module   : tb_left_shift
// Purpose  : Directed self-checking bench for left_shift (WIDTH=32, SHIFT=2).
//            Overflow checks are included when LEFT_SHIFT_OVF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_left_shift;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        load;
  logic [4:0]  shamt;
  logic [31:0] q_out;
  logic        q_valid;
`ifdef LEFT_SHIFT_OVF_EN
  logic        ovf;
  logic        q_ovf;
  logic        ovf_sticky;
`endif

  int tests;
  int failed;

  left_shift #(.WIDTH(32), .SHIFT(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out),
    .load     (load),
    .shamt    (shamt),
    .q_out    (q_out),
    .q_valid  (q_valid)
`ifdef LEFT_SHIFT_OVF_EN
    ,
    .ovf        (ovf),
    .q_ovf      (q_ovf),
    .ovf_sticky (ovf_sticky)
`endif
  );

  // Clock only toggles once the bench enables it, so the combinational
  // checks run with clk idle.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_then_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests   = 0;
    failed  = 0;
    clk_en  = 1'b0;
    rst     = 1'b1;
    load    = 1'b0;
    shamt   = 5'd0;
    data_in = 32'h0;
    #1;
    check("reset_q_out", q_out, 32'h0);
    check("reset_q_valid", {31'b0, q_valid}, 32'h0);
`ifdef LEFT_SHIFT_OVF_EN
    check("reset_q_ovf", {31'b0, q_ovf}, 32'h0);
    check("reset_sticky", {31'b0, ovf_sticky}, 32'h0);
`endif
    rst = 1'b0;
    #4;

    // Combinational path, clk idle, 5 ns after each apply.
    data_in = 32'h00000001; #5;
    check("comb_1", data_out, 32'h00000004);
    data_in = 32'hFFFFFFFF; #5;
    check("comb_ones", data_out, 32'hFFFFFFFC);
`ifdef LEFT_SHIFT_OVF_EN
    check("ovf_ones", {31'b0, ovf}, 32'h1);
`endif
    data_in = 32'h80000003; #5;
    check("comb_8003", data_out, 32'h0000000C);
`ifdef LEFT_SHIFT_OVF_EN
    check("ovf_8003", {31'b0, ovf}, 32'h1);
`endif
    data_in = 32'h40000000; #5;
    check("comb_4000", data_out, 32'h00000000);
`ifdef LEFT_SHIFT_OVF_EN
    check("ovf_4000", {31'b0, ovf}, 32'h1);
`endif
    data_in = 32'h00000000; #5;
    check("comb_zero", data_out, 32'h00000000);
`ifdef LEFT_SHIFT_OVF_EN
    check("ovf_zero", {31'b0, ovf}, 32'h0);
`endif
    data_in = 32'h3FFFFFFF; #5;
    check("comb_3fff", data_out, 32'hFFFFFFFC);
`ifdef LEFT_SHIFT_OVF_EN
    check("ovf_3fff", {31'b0, ovf}, 32'h0);
`endif

    // Walking one: bit i lands at i+2; bits 30 and 31 fall off.
    for (int i = 0; i < 32; i++) begin
      logic [31:0] one;
      one = 32'h1;
      data_in = one << i;
      #5;
      check($sformatf("walk_%0d", i), data_out, (i < 30) ? (one << (i + 2)) : 32'h0);
`ifdef LEFT_SHIFT_OVF_EN
      check($sformatf("walk_ovf_%0d", i), {31'b0, ovf}, (i >= 30) ? 32'h1 : 32'h0);
`endif
    end

    // Registered path.
    clk_en = 1'b1;
    @(negedge clk);
    load = 1'b1; shamt = 5'd31; data_in = 32'h00000001;
    edge_then_settle();
    check("reg_s31", q_out, 32'h80000000);
    check("reg_s31_valid", {31'b0, q_valid}, 32'h1);
    check("comb_during_reg", data_out, 32'h00000004);
`ifdef LEFT_SHIFT_OVF_EN
    check("reg_s31_qovf", {31'b0, q_ovf}, 32'h0);
`endif

    @(negedge clk);
    load = 1'b0; data_in = 32'h0000FFFF;
    edge_then_settle();
    check("reg_hold", q_out, 32'h80000000);
    check("reg_hold_valid", {31'b0, q_valid}, 32'h0);

    @(negedge clk);
    load = 1'b1; shamt = 5'd0; data_in = 32'hDEADBEEF;
    edge_then_settle();
    check("reg_s0", q_out, 32'hDEADBEEF);
`ifdef LEFT_SHIFT_OVF_EN
    check("reg_s0_qovf", {31'b0, q_ovf}, 32'h0);
    check("reg_s0_sticky", {31'b0, ovf_sticky}, 32'h0);
`endif

    @(negedge clk);
    shamt = 5'd16; data_in = 32'h0000ABCD;
    edge_then_settle();
    check("reg_s16", q_out, 32'hABCD0000);

    @(negedge clk);
    shamt = 5'd4; data_in = 32'h12345678;
    edge_then_settle();
    check("reg_s4", q_out, 32'h23456780);
    check("reg_s4_valid", {31'b0, q_valid}, 32'h1);
`ifdef LEFT_SHIFT_OVF_EN
    check("reg_s4_qovf", {31'b0, q_ovf}, 32'h1);
    check("reg_s4_sticky", {31'b0, ovf_sticky}, 32'h1);
`endif

    @(negedge clk);
    shamt = 5'd8; data_in = 32'h000000FF;
    edge_then_settle();
    check("reg_s8", q_out, 32'h0000FF00);
`ifdef LEFT_SHIFT_OVF_EN
    check("reg_s8_qovf", {31'b0, q_ovf}, 32'h0);
    check("reg_s8_sticky_held", {31'b0, ovf_sticky}, 32'h1);
`endif

    // Capture 0x23456780 again, then reset between edges.
    @(negedge clk);
    shamt = 5'd4; data_in = 32'h12345678;
    edge_then_settle();
    check("reg_recap", q_out, 32'h23456780);
    @(negedge clk);
    load = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_q_out", q_out, 32'h0);
    check("async_rst_valid", {31'b0, q_valid}, 32'h0);
    check("rst_data_out", data_out, 32'h48D159E0);
`ifdef LEFT_SHIFT_OVF_EN
    check("async_rst_qovf", {31'b0, q_ovf}, 32'h0);
    check("async_rst_sticky", {31'b0, ovf_sticky}, 32'h0);
`endif

    // Reset held across an edge with load=1: nothing captured.
    load = 1'b1;
    edge_then_settle();
    check("rst_held_q_out", q_out, 32'h0);
    check("rst_held_valid", {31'b0, q_valid}, 32'h0);

    // First edge after release captures normally.
    @(negedge clk);
    rst = 1'b0; shamt = 5'd1; data_in = 32'h80000001;
    edge_then_settle();
    check("post_rst_cap", q_out, 32'h00000002);
    check("post_rst_valid", {31'b0, q_valid}, 32'h1);
`ifdef LEFT_SHIFT_OVF_EN
    check("post_rst_qovf", {31'b0, q_ovf}, 32'h1);
    check("post_rst_sticky", {31'b0, ovf_sticky}, 32'h1);
`endif

    @(negedge clk);
    load = 1'b0;
    clk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
